uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 35 +++
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared UART types and constants (receiver and transmitter) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 314;

    // Mid-bit offset used to centre the sample point after the start edge.
    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff : two-flop synchroniser for a 1-bit asynchronous input      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    // Both stages reset high so an idle serial line never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx : 8N1 UART receiver with mid-bit sampling and framing check  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int          HALF        = half_bit(CLKS_PER_BIT);
    localparam logic [15:0] C_HALF_LAST = 16'(HALF - 1);
    localparam logic [15:0] C_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  C_IDX_LAST  = 3'(DATA_BITS - 1);

    logic rx_s;

    uart_state_e            state_d, state_q;
    logic [15:0]            cnt_d, cnt_q;
    logic [2:0]             bit_idx_d, bit_idx_q;
    logic [DATA_BITS-1:0]   shift_d, shift_q;
    logic [DATA_BITS-1:0]   data_d, data_q;
    logic                   valid_d, valid_q;
    logic                   ferr_d, ferr_q;

    sync_2ff u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end

            // A start bit that is high again at its midpoint was a glitch.
            START: begin
                if (cnt_q == C_HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == C_IDX_LAST) begin
                        state_d = STOP;
                    end
                end
            end

            // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
            STOP: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end

            // Held-low line: report once, then wait for it to return high.
            BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx : self-checking bench for uart_rx                         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_uart_rx;

    localparam int CPB = 314;
    localparam int LAT = 2985;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx        (rx),
        .o_data      (data),
        .o_valid     (valid),
        .o_frame_err (ferr),
        .o_busy      (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         valid_q[$];
    logic [7:0] vdata_q[$];
    int         ferr_q[$];
    int         both_cnt = 0;
    int         busy_cnt = 0;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            valid_q.push_back(cyc);
            vdata_q.push_back(data);
        end
        if (ferr === 1'b1) ferr_q.push_back(cyc);
        if (valid === 1'b1 && ferr === 1'b1) both_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic clear_mon();
        valid_q.delete();
        vdata_q.delete();
        ferr_q.delete();
        busy_cnt = 0;
    endtask

    // Drives start, 8 data bits LSB first and a stop bit; c0 is the cycle of e0.
    task automatic send_frame(input logic [7:0] d, input logic stop_val,
                              input int cpb, output int c0);
        @(negedge clk);
        rx = 1'b0;
        c0 = cyc + 1;
        repeat (cpb - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (cpb) @(negedge clk);
        end
        rx = stop_val;
        repeat (cpb) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] d;
        int         cpb;
        logic [7:0] exp_data;
        int         exp_lat;   // -1: latency not fixed at this bit rate
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1;

        vecs[0] = '{d: 8'h55, cpb: 314, exp_data: 8'h55, exp_lat: LAT};
        vecs[1] = '{d: 8'hA3, cpb: 314, exp_data: 8'hA3, exp_lat: LAT};
        vecs[2] = '{d: 8'hC5, cpb: 320, exp_data: 8'hC5, exp_lat: -1};
        vecs[3] = '{d: 8'hC5, cpb: 308, exp_data: 8'hC5, exp_lat: -1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_data",  data,  0);
        chk("reset_valid", valid, 0);
        chk("reset_ferr",  ferr,  0);
        chk("reset_busy",  busy,  0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Table-driven good frames
        foreach (vecs[n]) begin
            clear_mon();
            send_frame(vecs[n].d, 1'b1, vecs[n].cpb, c0);
            repeat (20) @(negedge clk);
            chk($sformatf("vec%0d_valid_cnt", n), valid_q.size(), 1);
            chk($sformatf("vec%0d_ferr_cnt", n), ferr_q.size(), 0);
            chk($sformatf("vec%0d_busy", n), busy, 0);
            chk($sformatf("vec%0d_o_data", n), data, vecs[n].exp_data);
            if (valid_q.size() > 0) begin
                chk($sformatf("vec%0d_pulse_data", n), vdata_q[0], vecs[n].exp_data);
                if (vecs[n].exp_lat >= 0)
                    chk($sformatf("vec%0d_latency", n), valid_q[0] - c0, vecs[n].exp_lat);
            end
        end

        // Start glitch of 100 cycles
        clear_mon();
        @(negedge clk);
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (400) @(negedge clk);
        chk("glitch_busy_cycles", busy_cnt, 157);
        chk("glitch_valid_cnt", valid_q.size(), 0);
        chk("glitch_ferr_cnt", ferr_q.size(), 0);
        chk("glitch_busy_end", busy, 0);

        // Framing error with line held low afterwards
        clear_mon();
        send_frame(8'h0F, 1'b0, CPB, c0);
        repeat (2000) @(negedge clk);
        chk("ferr_cnt", ferr_q.size(), 1);
        if (ferr_q.size() > 0) chk("ferr_latency", ferr_q[0] - c0, LAT);
        chk("ferr_valid_cnt", valid_q.size(), 0);
        chk("ferr_data_held", data, 8'hC5);
        chk("ferr_busy_held", busy, 1);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("ferr_busy_release", busy, 0);
        chk("ferr_cnt_final", ferr_q.size(), 1);

        // Back-to-back frames
        clear_mon();
        send_frame(8'h00, 1'b1, CPB, c0);
        send_frame(8'hFF, 1'b1, CPB, c1);
        send_frame(8'h81, 1'b1, CPB, c1);
        repeat (20) @(negedge clk);
        chk("b2b_valid_cnt", valid_q.size(), 3);
        chk("b2b_ferr_cnt", ferr_q.size(), 0);
        if (valid_q.size() == 3) begin
            chk("b2b_data0", vdata_q[0], 8'h00);
            chk("b2b_data1", vdata_q[1], 8'hFF);
            chk("b2b_data2", vdata_q[2], 8'h81);
            chk("b2b_latency0", valid_q[0] - c0, LAT);
            chk("b2b_spacing01", valid_q[1] - valid_q[0], 3140);
            chk("b2b_spacing12", valid_q[2] - valid_q[1], 3140);
        end

        // Reset during bit 4 of a frame, then a clean frame
        clear_mon();
        begin
            logic [7:0] ab;
            ab = 8'h5A;
            @(negedge clk);
            rx = 1'b0;
            repeat (CPB) @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                rx = ab[i];
                repeat (CPB) @(negedge clk);
            end
            rx = ab[4];
        end
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_data",  data,  0);
        chk("midrst_valid", valid, 0);
        chk("midrst_ferr",  ferr,  0);
        chk("midrst_busy",  busy,  0);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3000) @(negedge clk);
        chk("midrst_no_valid", valid_q.size(), 0);
        chk("midrst_no_ferr", ferr_q.size(), 0);
        send_frame(8'h3C, 1'b1, CPB, c0);
        repeat (20) @(negedge clk);
        chk("post_rst_valid_cnt", valid_q.size(), 1);
        chk("post_rst_data", data, 8'h3C);
        if (valid_q.size() > 0) chk("post_rst_latency", valid_q[0] - c0, LAT);

        chk("valid_ferr_exclusive", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
